// File: rtl/machine_csr_file.sv
// ============================================================================
// Module   : machine_csr_file
// Purpose  : Machine-mode CSR storage, trap/mret sequencer and PC redirect.
//            Optional mcycle counter at indices 9/10 when CSR_MCYCLE_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module machine_csr_file #(
    parameter logic [31:0] MISA_VAL  = 32'h40000100,
    parameter logic [31:0] MTVEC_RST = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  csr_add,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_sw,
    output logic        irq_pending,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [31:0] c_MSTATUS_MASK = 32'h00000088;
    localparam logic [31:0] c_MPP_READ     = 32'h00001800;
    localparam logic [31:0] c_MIE_MASK     = 32'h00000888;
    localparam logic [31:0] c_MTVEC_MASK   = 32'hFFFFFFFD;
    localparam logic [31:0] c_MEPC_MASK    = 32'hFFFFFFFC;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_mstatus;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [31:0] r_mip;
    logic [31:0] r_redirect_pc;
    logic [31:0] w_wr_val;
    logic [31:0] w_base;
    logic [31:0] w_trap_target;
    logic        w_wr_en;
`ifdef CSR_MCYCLE_EN
    logic [63:0] r_mcycle;
`endif

    // Read path always shows the pre-edge value of the addressed register
    always_comb begin
        csr_rdata = 32'h0;
        case (csr_add)
            4'd0: csr_rdata = r_mstatus | c_MPP_READ;
            4'd1: csr_rdata = MISA_VAL;
            4'd2: csr_rdata = r_mie;
            4'd3: csr_rdata = r_mtvec;
            4'd4: csr_rdata = r_mepc;
            4'd5: csr_rdata = r_mcause;
            4'd6: csr_rdata = r_mtval;
            4'd7: csr_rdata = r_mip;
`ifdef CSR_MCYCLE_EN
            4'd9:  csr_rdata = r_mcycle[31:0];
            4'd10: csr_rdata = r_mcycle[63:32];
`endif
            default: csr_rdata = 32'h0;
        endcase
    end

`ifdef CSR_MCYCLE_EN
    assign csr_illegal = (csr_op != 2'b00) && ((csr_add == 4'd8) || (csr_add >= 4'd11));
`else
    assign csr_illegal = (csr_op != 2'b00) && (csr_add >= 4'd8);
`endif

    always_comb begin
        w_wr_val = csr_wdata;
        case (csr_op)
            2'b10:   w_wr_val = csr_rdata | csr_wdata;
            2'b11:   w_wr_val = csr_rdata & ~csr_wdata;
            default: w_wr_val = csr_wdata;
        endcase
    end

    // Trap and mret both take precedence over a concurrent CSR write
    assign w_wr_en       = (csr_op != 2'b00) && !csr_illegal && !trap_req && !mret;
    assign w_base        = {r_mtvec[31:2], 2'b00};
    assign w_trap_target = (r_mtvec[0] && trap_cause[31])
                         ? w_base + {25'h0, trap_cause[4:0], 2'b00}
                         : w_base;

    assign irq_pending    = r_mstatus[3] & (|(r_mip & r_mie));
    assign redirect_valid = (r_state == REDIRECT);
    assign redirect_pc    = r_redirect_pc;

    always_comb begin
        w_state_next = RUN;
        if (trap_req || mret) begin
            w_state_next = REDIRECT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_mstatus     <= 32'h0;
            r_mie         <= 32'h0;
            r_mtvec       <= MTVEC_RST & c_MTVEC_MASK;
            r_mepc        <= 32'h0;
            r_mcause      <= 32'h0;
            r_mtval       <= 32'h0;
            r_mip         <= 32'h0;
            r_redirect_pc <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_mip   <= {20'h0, irq_ext, 3'b000, irq_timer, 3'b000, irq_sw, 3'b000};
            if (trap_req) begin
                r_mepc        <= trap_pc & c_MEPC_MASK;
                r_mcause      <= trap_cause;
                r_mtval       <= trap_tval;
                r_mstatus     <= {24'h0, r_mstatus[3], 7'h0};
                r_redirect_pc <= w_trap_target;
            end else if (mret) begin
                r_mstatus     <= {24'h0, 1'b1, 3'b000, r_mstatus[7], 3'b000};
                r_redirect_pc <= r_mepc;
            end else if (w_wr_en) begin
                case (csr_add)
                    4'd0:    r_mstatus <= w_wr_val & c_MSTATUS_MASK;
                    4'd2:    r_mie     <= w_wr_val & c_MIE_MASK;
                    4'd3:    r_mtvec   <= w_wr_val & c_MTVEC_MASK;
                    4'd4:    r_mepc    <= w_wr_val & c_MEPC_MASK;
                    4'd5:    r_mcause  <= w_wr_val;
                    4'd6:    r_mtval   <= w_wr_val;
                    default: ;
                endcase
            end
        end
    end

`ifdef CSR_MCYCLE_EN
    // A CSR write to either half replaces that half and skips the increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcycle <= 64'h0;
        end else if (w_wr_en && (csr_add == 4'd9)) begin
            r_mcycle <= {r_mcycle[63:32], w_wr_val};
        end else if (w_wr_en && (csr_add == 4'd10)) begin
            r_mcycle <= {w_wr_val, r_mcycle[31:0]};
        end else begin
            r_mcycle <= r_mcycle + 64'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_machine_csr_file.sv
// ============================================================================
// Module   : tb_machine_csr_file
// Purpose  : Self-checking bench for machine_csr_file; redirects are checked
//            against a scoreboard queue filled when traps/mrets are driven.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_machine_csr_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  csr_add;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret;
    logic        irq_ext;
    logic        irq_timer;
    logic        irq_sw;
    logic        irq_pending;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] redirect_q[$];

    machine_csr_file dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .csr_add        (csr_add),
        .csr_op         (csr_op),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .csr_illegal    (csr_illegal),
        .trap_req       (trap_req),
        .trap_cause     (trap_cause),
        .trap_pc        (trap_pc),
        .trap_tval      (trap_tval),
        .mret           (mret),
        .irq_ext        (irq_ext),
        .irq_timer      (irq_timer),
        .irq_sw         (irq_sw),
        .irq_pending    (irq_pending),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // Redirect monitor: every pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (redirect_valid) begin
            checks++;
            if (redirect_q.size() == 0) begin
                errors++;
                $display("FAIL redirect_unexpected: got pc=%08h with no pending expectation", redirect_pc);
            end else begin
                logic [31:0] exp_pc;
                exp_pc = redirect_q.pop_front();
                if (redirect_pc !== exp_pc) begin
                    errors++;
                    $display("FAIL redirect_pc: got %08h expected %08h", redirect_pc, exp_pc);
                end
            end
        end
    end

    // One cycle of CSR access; returns with inputs applied and outputs settled
    task automatic drive(input logic [3:0] add, input logic [1:0] op, input logic [31:0] wd);
        @(negedge clk);
        trap_req  = 1'b0;
        mret      = 1'b0;
        csr_add   = add;
        csr_op    = op;
        csr_wdata = wd;
        #1;
    endtask

    task automatic start_trap(input logic [31:0] cause, input logic [31:0] pc,
                              input logic [31:0] tval, input logic [31:0] exp_target);
        @(negedge clk);
        trap_req   = 1'b1;
        mret       = 1'b0;
        trap_cause = cause;
        trap_pc    = pc;
        trap_tval  = tval;
        csr_op     = 2'b00;
        redirect_q.push_back(exp_target);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] exp;
        rst_n = 1'b0; csr_add = 4'd0; csr_op = 2'b00; csr_wdata = 32'h0;
        trap_req = 1'b0; trap_cause = 32'h0; trap_pc = 32'h0; trap_tval = 32'h0;
        mret = 1'b0; irq_ext = 1'b0; irq_timer = 1'b0; irq_sw = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            drive(4'(i), 2'b00, 32'h0);
            exp = (i == 1) ? 32'h40000100 : ((i == 0) ? 32'h00001800 : 32'h0);
            checks++;
            if (csr_rdata !== exp || csr_illegal !== 1'b0) begin
                errors++;
                $display("FAIL reset_read[%0d]: got %08h ill=%b expected %08h ill=0", i, csr_rdata, csr_illegal, exp);
            end
        end
        checks++;
        if (redirect_valid !== 1'b0 || irq_pending !== 1'b0 || redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b pend=%b pc=%08h expected 0/0/0", redirect_valid, irq_pending, redirect_pc);
        end
    endtask

    task automatic test_trap_vectored;
        logic [31:0] exp [0:6];
        logic [31:0] got [0:6];
        drive(4'd0, 2'b01, 32'h8);        got[0] = csr_rdata;
        drive(4'd3, 2'b01, 32'h101);      got[1] = csr_rdata;
        drive(4'd3, 2'b00, 32'h0);        got[2] = csr_rdata;
        start_trap(32'h8000000B, 32'h46, 32'h1234, 32'h12C);
        drive(4'd4, 2'b00, 32'h0);        got[3] = csr_rdata;
        drive(4'd0, 2'b00, 32'h0);        got[4] = csr_rdata;
        drive(4'd5, 2'b00, 32'h0);        got[5] = csr_rdata;
        drive(4'd6, 2'b00, 32'h0);        got[6] = csr_rdata;
        exp[0] = 32'h1800; exp[1] = 32'h0; exp[2] = 32'h101; exp[3] = 32'h44;
        exp[4] = 32'h1880; exp[5] = 32'h8000000B; exp[6] = 32'h1234;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL trap_vectored[%0d]: got %08h expected %08h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_irq_mret;
        logic [31:0] st;
        drive(4'd2, 2'b01, 32'h800);
        drive(4'd0, 2'b10, 32'h8);
        drive(4'd7, 2'b00, 32'h0);
        irq_ext = 1'b1;
        #1;
        checks++;
        if (irq_pending !== 1'b0) begin
            errors++;
            $display("FAIL irq_latency: got pending=%b expected 0", irq_pending);
        end
        drive(4'd7, 2'b00, 32'h0);
        checks++;
        if (irq_pending !== 1'b1 || csr_rdata !== 32'h800) begin
            errors++;
            $display("FAIL irq_pending: got pend=%b mip=%08h expected 1/00000800", irq_pending, csr_rdata);
        end
        irq_ext = 1'b0;
        drive(4'd7, 2'b00, 32'h0);
        checks++;
        if (irq_pending !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: got pending=%b expected 0", irq_pending);
        end
        start_trap(32'h2, 32'h200, 32'h0, 32'h100);
        drive(4'd0, 2'b00, 32'h0);
        st = csr_rdata;
        @(negedge clk);
        mret = 1'b1;
        redirect_q.push_back(32'h200);
        drive(4'd0, 2'b00, 32'h0);
        checks++;
        if (st !== 32'h1880 || csr_rdata !== 32'h1888) begin
            errors++;
            $display("FAIL mret_mstatus: got trap=%08h mret=%08h expected 00001880/00001888", st, csr_rdata);
        end
    endtask

    task automatic test_csrrc_illegal;
        logic [31:0] got [0:8];
        logic [31:0] exp [0:8];
        logic        ill;
        drive(4'd2, 2'b01, 32'h888);       got[0] = csr_rdata;
        drive(4'd2, 2'b11, 32'h80);        got[1] = csr_rdata;
        drive(4'd2, 2'b00, 32'h0);         got[2] = csr_rdata;
        drive(4'd8, 2'b01, 32'hFFFFFFFF);  got[3] = csr_rdata; ill = csr_illegal;
        drive(4'd2, 2'b00, 32'h0);         got[4] = csr_rdata;
        drive(4'd1, 2'b01, 32'h0);
        drive(4'd1, 2'b00, 32'h0);         got[5] = csr_rdata;
        drive(4'd4, 2'b01, 32'h12345677);
        drive(4'd4, 2'b00, 32'h0);         got[6] = csr_rdata;
        drive(4'd3, 2'b01, 32'hFFFFFFFF);
        drive(4'd3, 2'b01, 32'h101);       got[7] = csr_rdata;
        drive(4'd3, 2'b00, 32'h0);         got[8] = csr_rdata;
        exp[0] = 32'h800; exp[1] = 32'h888; exp[2] = 32'h808; exp[3] = 32'h0;
        exp[4] = 32'h808; exp[5] = 32'h40000100; exp[6] = 32'h12345674;
        exp[7] = 32'hFFFFFFFD; exp[8] = 32'h101;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin
                errors++;
                $display("FAIL csr_rmw[%0d]: got %08h expected %08h", i, got[i], exp[i]);
            end
        end
        checks++;
        if (ill !== 1'b1) begin
            errors++;
            $display("FAIL illegal_idx8: got %b expected 1", ill);
        end
    endtask

    task automatic test_priority;
        logic [31:0] old_rd;
        logic [31:0] got [0:2];
        start_trap(32'h5, 32'h303, 32'h0, 32'h100);
        csr_add = 4'd4; csr_op = 2'b01; csr_wdata = 32'hDEAD0000;
        #1;
        old_rd = csr_rdata;
        drive(4'd4, 2'b00, 32'h0);
        checks++;
        if (old_rd !== 32'h12345674 || csr_rdata !== 32'h300) begin
            errors++;
            $display("FAIL trap_vs_write: got old=%08h mepc=%08h expected 12345674/00000300", old_rd, csr_rdata);
        end
        start_trap(32'h80000007, 32'h400, 32'h0, 32'h11C);
        mret = 1'b1; csr_add = 4'd3; csr_op = 2'b01; csr_wdata = 32'h800;
        drive(4'd4, 2'b00, 32'h0);  got[0] = csr_rdata;
        drive(4'd3, 2'b00, 32'h0);  got[1] = csr_rdata;
        drive(4'd5, 2'b00, 32'h0);  got[2] = csr_rdata;
        checks++;
        if (got[0] !== 32'h400 || got[1] !== 32'h101 || got[2] !== 32'h80000007) begin
            errors++;
            $display("FAIL trap_vs_mret: got mepc=%08h mtvec=%08h mcause=%08h expected 00000400/00000101/80000007",
                     got[0], got[1], got[2]);
        end
    endtask

    task automatic test_mcycle;
`ifdef CSR_MCYCLE_EN
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ill9;
        logic        ill11;
        drive(4'd9, 2'b01, 32'hFFFFFFFF);  ill9 = csr_illegal;
        drive(4'd10, 2'b01, 32'hFFFFFFFF);
        drive(4'd10, 2'b00, 32'h0);        hi = csr_rdata;
        drive(4'd9, 2'b00, 32'h0);         lo = csr_rdata;
        drive(4'd11, 2'b01, 32'h0);        ill11 = csr_illegal;
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'h0) begin
            errors++;
            $display("FAIL mcycle_wrap: got hi=%08h lo=%08h expected ffffffff/00000000", hi, lo);
        end
        checks++;
        if (ill9 !== 1'b0 || ill11 !== 1'b1) begin
            errors++;
            $display("FAIL mcycle_illegal: got idx9=%b idx11=%b expected 0/1", ill9, ill11);
        end
`else
        logic ill9;
        drive(4'd9, 2'b01, 32'hFFFFFFFF);  ill9 = csr_illegal;
        drive(4'd9, 2'b00, 32'h0);
        checks++;
        if (ill9 !== 1'b1 || csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL idx9_no_mcycle: got ill=%b rd=%08h expected 1/00000000", ill9, csr_rdata);
        end
`endif
    endtask

    task automatic test_back_to_back;
        start_trap(32'h80000003, 32'h500, 32'h0, 32'h10C);
        start_trap(32'h0000000B, 32'h600, 32'h0, 32'h100);
        drive(4'd4, 2'b00, 32'h0);
        checks++;
        if (csr_rdata !== 32'h600) begin
            errors++;
            $display("FAIL back_to_back_mepc: got %08h expected 00000600", csr_rdata);
        end
        drive(4'd0, 2'b00, 32'h0);
        checks++;
        if (redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_width: got valid=%b expected 0", redirect_valid);
        end
        start_trap(32'h1, 32'h700, 32'h0, 32'h100);
        @(negedge clk);
        trap_req = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_redirect: got valid=%b pc=%08h expected 0/00000000", redirect_valid, redirect_pc);
        end
        rst_n = 1'b1;
        drive(4'd3, 2'b00, 32'h0);
        checks++;
        if (csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mtvec: got %08h expected 00000000", csr_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_trap_vectored();
        test_irq_mret();
        test_csrrc_illegal();
        test_priority();
        test_mcycle();
        test_back_to_back();
        repeat (4) @(negedge clk);
        checks++;
        if (redirect_q.size() != 0) begin
            errors++;
            $display("FAIL redirect_missing: got %0d unserved expectations expected 0", redirect_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
